// File: rtl/soml_frame_ctrl.sv
// Frame sequencer that feeds one frame of H and Y samples into a SOML decoder and returns its result.
// Optional WAIT watchdog is built only when SOML_FRAME_TIMEOUT_EN is defined.
module soml_frame_ctrl #(
  parameter int N       = 32,
  parameter int H_LEN   = 32,
  parameter int Y_LEN   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [N-1:0] s_data_r,
  input  logic signed [N-1:0] s_data_i,
  output logic                dec_start,
  output logic                dec_H_valid,
  output logic signed [N-1:0] dec_H_r,
  output logic signed [N-1:0] dec_H_i,
  output logic                dec_Y_valid,
  output logic signed [N-1:0] dec_Y_r,
  output logic signed [N-1:0] dec_Y_i,
  input  logic                dec_out_valid,
  input  logic [4:0]          dec_Smin_index,
  input  logic [11:0]         dec_signal,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [4:0]          r_index,
  output logic [11:0]         r_signal,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic                timeout_err
);

  if ((H_LEN < 1) || (H_LEN > 255) || (Y_LEN < 1) || (Y_LEN > 255) ||
      (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_check
    $error("soml_frame_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_H,
    S_LOAD_Y,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [7:0] H_LAST = 8'(H_LEN - 1);
  localparam logic [7:0] Y_LAST = 8'(Y_LEN - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       load_h_xfer, load_y_xfer;
  logic       capture, release_r;

`ifdef SOML_FRAME_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;
  logic        timeout_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // The sample counter only advances on real transfers, so s_valid gaps simply stall the phase.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    s_ready     = 1'b0;
    dec_start   = 1'b0;
    busy        = (state != S_IDLE);
    load_h_xfer = 1'b0;
    load_y_xfer = 1'b0;
    capture     = 1'b0;
    release_r   = 1'b0;
`ifdef SOML_FRAME_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (s_valid) state_next = S_START;
      end
      S_START: begin
        dec_start  = 1'b1;
        cnt_next   = 8'd0;
        state_next = S_LOAD_H;
      end
      S_LOAD_H: begin
        s_ready     = 1'b1;
        load_h_xfer = s_valid;
        if (s_valid) begin
          if (cnt == H_LAST) begin
            cnt_next   = 8'd0;
            state_next = S_LOAD_Y;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      S_LOAD_Y: begin
        s_ready     = 1'b1;
        load_y_xfer = s_valid;
        if (s_valid) begin
          if (cnt == Y_LAST) begin
            cnt_next   = 8'd0;
            state_next = S_WAIT;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (dec_out_valid) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
`ifdef SOML_FRAME_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
`endif
      end
      S_HOLD: begin
        if (r_ready) begin
          release_r  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 8'd0;
      dec_H_valid <= 1'b0;
      dec_H_r     <= '0;
      dec_H_i     <= '0;
      dec_Y_valid <= 1'b0;
      dec_Y_r     <= '0;
      dec_Y_i     <= '0;
      r_valid     <= 1'b0;
      r_index     <= 5'd0;
      r_signal    <= 12'd0;
      frame_cnt   <= 16'd0;
    end else begin
      cnt         <= cnt_next;
      dec_H_valid <= load_h_xfer;
      dec_Y_valid <= load_y_xfer;
      if (load_h_xfer) begin
        dec_H_r <= s_data_r;
        dec_H_i <= s_data_i;
      end
      if (load_y_xfer) begin
        dec_Y_r <= s_data_r;
        dec_Y_i <= s_data_i;
      end
      if (capture) begin
        r_valid  <= 1'b1;
        r_index  <= dec_Smin_index;
        r_signal <= dec_signal;
      end else if (release_r) begin
        r_valid   <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef SOML_FRAME_TIMEOUT_EN
  // Watchdog counts WAIT cycles; the error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
      else                 wait_cnt <= 16'd0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_soml_frame_ctrl.sv
// Randomized self-checking bench for soml_frame_ctrl against a frame-level reference model.
// Covers nominal, gapped, backpressure, spurious results, mid-load reset and (if enabled) the WAIT watchdog.
module tb_soml_frame_ctrl;
  localparam int N       = 32;
  localparam int H_LEN   = 32;
  localparam int Y_LEN   = 2;
  localparam int TIMEOUT = 20;
  localparam int TOTAL   = H_LEN + Y_LEN;
  localparam int BUDGET  = 2000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [N-1:0] s_data_r = '0;
  logic signed [N-1:0] s_data_i = '0;
  logic                dec_start;
  logic                dec_H_valid;
  logic signed [N-1:0] dec_H_r, dec_H_i;
  logic                dec_Y_valid;
  logic signed [N-1:0] dec_Y_r, dec_Y_i;
  logic                dec_out_valid = 1'b0;
  logic [4:0]          dec_Smin_index = '0;
  logic [11:0]         dec_signal = '0;
  logic                r_valid;
  logic                r_ready = 1'b0;
  logic [4:0]          r_index;
  logic [11:0]         r_signal;
  logic                busy;
  logic [15:0]         frame_cnt;
  logic                timeout_err;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames = '0;
  logic        exp_terr = 1'b0;

  soml_frame_ctrl #(.N(N), .H_LEN(H_LEN), .Y_LEN(Y_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_r(s_data_r), .s_data_i(s_data_i),
    .dec_start(dec_start),
    .dec_H_valid(dec_H_valid), .dec_H_r(dec_H_r), .dec_H_i(dec_H_i),
    .dec_Y_valid(dec_Y_valid), .dec_Y_r(dec_Y_r), .dec_Y_i(dec_Y_i),
    .dec_out_valid(dec_out_valid), .dec_Smin_index(dec_Smin_index), .dec_signal(dec_signal),
    .r_valid(r_valid), .r_ready(r_ready), .r_index(r_index), .r_signal(r_signal),
    .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic newSample();
    s_data_r = N'($urandom);
    s_data_i = N'($urandom);
  endtask

  task automatic resetDut();
    rst           = 1'b1;
    s_valid       = 1'b0;
    dec_out_valid = 1'b0;
    r_ready       = 1'b0;
    tick();
    checkOutput("reset_ctrl", {busy, s_ready, dec_start, dec_H_valid, dec_Y_valid, r_valid, timeout_err}, 0);
    checkOutput("reset_data", {dec_H_r, dec_H_i, r_index, r_signal}, 0);
    checkOutput("reset_ydata", {dec_Y_r, dec_Y_i}, 0);
    checkOutput("reset_frame_cnt", frame_cnt, 0);
    rst        = 1'b0;
    exp_frames = '0;
    exp_terr   = 1'b0;
  endtask

  // Streams one frame: mode 0 back-to-back, 1 alternating, 2 random gaps.
  // Every accepted sample must reappear on the matching decoder port exactly one cycle later.
  task automatic applyStimulus(input int mode, input int abort_after, input bit spurious);
    int          sent = 0, starts = 0, cycles = 0, h_seen = 0, y_seen = 0;
    bit          accept, exp_h, exp_y, rv_seen = 0;
    logic [63:0] exp_d;
    s_valid = 1'b1;
    newSample();
    while (sent < TOTAL && cycles < BUDGET) begin
      accept = s_valid && s_ready;
      exp_h  = accept && (sent < H_LEN);
      exp_y  = accept && (sent >= H_LEN);
      exp_d  = {s_data_r, s_data_i};
      if (accept) sent++;
      if (spurious) begin
        dec_out_valid  = 1'($urandom_range(0, 1));
        dec_Smin_index = 5'($urandom);
        dec_signal     = 12'($urandom);
      end
      tick();
      cycles++;
      if (dec_start) starts++;
      if (r_valid) rv_seen = 1;
      if (dec_H_valid) h_seen++;
      if (dec_Y_valid) y_seen++;
      checkOutput("dec_H_valid", dec_H_valid, exp_h);
      checkOutput("dec_Y_valid", dec_Y_valid, exp_y);
      if (exp_h) checkOutput("dec_H_data", {dec_H_r, dec_H_i}, exp_d);
      if (exp_y) checkOutput("dec_Y_data", {dec_Y_r, dec_Y_i}, exp_d);
      if (abort_after > 0 && sent == abort_after) break;
      if (sent >= TOTAL) begin
        s_valid = 1'b0;
      end else if (!(s_valid && !accept)) begin
        case (mode)
          0:       s_valid = 1'b1;
          1:       s_valid = !s_valid;
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        if (s_valid) newSample();
      end
    end
    dec_out_valid = 1'b0;
    checkOutput("load_budget", cycles < BUDGET, 1);
    checkOutput("dec_start_pulses", starts, 1);
    checkOutput("r_valid_during_load", rv_seen, 0);
    if (abort_after > 0) begin
      checkOutput("h_before_abort", h_seen, abort_after);
    end else begin
      checkOutput("h_count", h_seen, H_LEN);
      checkOutput("y_count", y_seen, Y_LEN);
      checkOutput("wait_s_ready", s_ready, 0);
      checkOutput("wait_busy", busy, 1);
      checkOutput("timeout_err_load", timeout_err, exp_terr);
    end
  endtask

  // Decoder answers after 'delay' idle WAIT cycles; result is then held for 'bp' cycles of backpressure.
  task automatic runResult(input int delay, input logic [4:0] idx, input logic [11:0] sig, input int bp);
    repeat (delay) tick();
    dec_out_valid  = 1'b1;
    dec_Smin_index = idx;
    dec_signal     = sig;
    tick();
    checkOutput("r_valid_set", r_valid, 1);
    checkOutput("r_index", r_index, idx);
    checkOutput("r_signal", r_signal, sig);
    checkOutput("timeout_err_result", timeout_err, exp_terr);
    s_valid = 1'b1;
    newSample();
    for (int i = 0; i < bp; i++) begin
      dec_out_valid  = 1'($urandom_range(0, 1));
      dec_Smin_index = 5'($urandom);
      dec_signal     = 12'($urandom);
      tick();
      checkOutput("hold_result", {r_valid, r_index, r_signal}, {1'b1, idx, sig});
      checkOutput("hold_ctrl", {s_ready, dec_start, busy}, 3'b001);
      checkOutput("hold_frame_cnt", frame_cnt, exp_frames);
    end
    dec_out_valid = 1'b0;
    r_ready       = 1'b1;
    tick();
    r_ready    = 1'b0;
    s_valid    = 1'b0;
    exp_frames = exp_frames + 16'd1;
    checkOutput("release_r_valid", r_valid, 0);
    checkOutput("release_busy", busy, 0);
    checkOutput("frame_cnt", frame_cnt, exp_frames);
  endtask

  initial begin
    tick();
    resetDut();

    applyStimulus(0, 0, 0);
    runResult(2, 5'd17, 12'h3A5, 0);

    applyStimulus(1, 0, 0);
    runResult(3, 5'($urandom), 12'($urandom), 10);

    applyStimulus(2, 0, 1);
    runResult(1, 5'($urandom), 12'($urandom), 3);

    applyStimulus(0, 10, 0);
    resetDut();
    applyStimulus(0, 0, 0);
    runResult(0, 5'($urandom), 12'($urandom), 1);

`ifdef SOML_FRAME_TIMEOUT_EN
    applyStimulus(0, 0, 0);
    runResult(TIMEOUT - 1, 5'($urandom), 12'($urandom), 2);

    applyStimulus(0, 0, 0);
    repeat (TIMEOUT - 1) tick();
    checkOutput("pre_timeout", {timeout_err, busy}, 2'b01);
    tick();
    checkOutput("timeout_flag", timeout_err, 1);
    checkOutput("timeout_idle", {busy, r_valid, s_ready}, 0);
    checkOutput("timeout_frame_cnt", frame_cnt, exp_frames);
    exp_terr = 1'b1;
`else
    applyStimulus(0, 0, 0);
    repeat (3 * TIMEOUT) tick();
    checkOutput("unbounded_wait", {busy, timeout_err, r_valid}, 3'b100);
    runResult(0, 5'($urandom), 12'($urandom), 0);
`endif

    for (int f = 0; f < 4; f++) begin
      applyStimulus(int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
      runResult(int'($urandom_range(0, 8)), 5'($urandom), 12'($urandom), int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/soml_frame_ctrl.md
SOML_FRAME_CTRL -- requirements
Module: soml_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, sample width of real and imaginary parts.
REQ-002 SHALL have parameter H_LEN, default 32, complex H samples per frame (range 1..255).
REQ-003 SHALL have parameter Y_LEN, default 2, complex Y samples per frame (range 1..255).
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles (range 1..65535).
REQ-005 SHALL have port clk input 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst input 1: synchronous, active-high reset.
REQ-007 SHALL have ports s_valid input 1, s_ready output 1: upstream sample handshake.
REQ-008 SHALL have ports s_data_r, s_data_i input N, signed: upstream complex sample.
REQ-009 SHALL have port dec_start output 1: decoder start pulse.
REQ-010 SHALL have ports dec_H_valid output 1 and dec_H_r, dec_H_i output N: decoder H load.
REQ-011 SHALL have ports dec_Y_valid output 1 and dec_Y_r, dec_Y_i output N: decoder Y load.
REQ-012 SHALL have ports dec_out_valid input 1, dec_Smin_index input 5, dec_signal input 12: decoder result.
REQ-013 SHALL have ports r_valid output 1, r_ready input 1, r_index output 5, r_signal output 12: result handshake.
REQ-014 SHALL have ports busy output 1, frame_cnt output 16, timeout_err output 1: status.

Function
REQ-015 SHALL implement FSM IDLE, START, LOAD_H, LOAD_Y, WAIT, HOLD.
REQ-016 IDLE: s_ready=0; s_valid=1 -> START; the sample is not consumed.
REQ-017 START: dec_start=1 for exactly one cycle -> LOAD_H; s_ready=0.
REQ-018 LOAD_H/LOAD_Y: s_ready=1; each transfer (s_valid & s_ready) SHALL drive dec_H_valid (or dec_Y_valid) with the registered data on the following cycle, one cycle latency.
REQ-019 The sample counter SHALL count transfers only; after transfer H_LEN the FSM -> LOAD_Y; after transfer Y_LEN -> WAIT; the counter clears on each phase change.
REQ-020 s_valid gaps SHALL stall loading with no timeout and no data loss; dec_*_valid SHALL be 0 on cycles without a transfer.
REQ-021 WAIT: s_ready=0; dec_out_valid=1 -> capture dec_Smin_index and dec_signal into r_index and r_signal, set r_valid=1 -> HOLD.
REQ-022 HOLD: r_valid, r_index and r_signal stable until r_ready=1; on that cycle r_valid clears, frame_cnt increments (wraps 0xFFFF->0) -> IDLE.
REQ-023 dec_out_valid outside WAIT SHALL be ignored.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 A new frame SHALL not start before the HOLD handshake completes (no overlap).

Reset
REQ-026 rst=1 at any clock edge SHALL force IDLE and clear all outputs, counters, frame_cnt and timeout_err to 0, including mid-load and mid-WAIT.
REQ-027 After a mid-frame reset the next frame SHALL begin with a fresh START pulse.

Configuration
REQ-028 Macro SOML_FRAME_TIMEOUT_EN defined: the WAIT cycle counter reaching TIMEOUT without dec_out_valid SHALL set sticky timeout_err, produce no result and -> IDLE; dec_out_valid on the TIMEOUT cycle itself takes priority (normal capture).
REQ-029 Macro not defined: WAIT SHALL be unbounded, timeout_err tied 0, and no timeout counter logic present.

Verification
REQ-030 Nominal: 34 back-to-back samples; dec_start one pulse; 32 dec_H_valid then 2 dec_Y_valid; dec_out_valid with index 5'd17, signal 12'h3A5 -> r_valid=1, r_index=17, r_signal=0x3A5; r_ready -> frame_cnt=1.
REQ-031 Gapped input: s_valid toggles every other cycle -> exactly 32 H and 2 Y valids in order, data matches input sequence.
REQ-032 Backpressure: r_ready held 0 for 10 cycles -> r_* stable, s_ready=0, frame_cnt unchanged until release.
REQ-033 Reset during LOAD_H after 10 samples -> all outputs 0 next cycle; following frame loads a full 32 H.
REQ-034 With SOML_FRAME_TIMEOUT_EN, TIMEOUT=20, no dec_out_valid -> timeout_err=1 after 20 WAIT cycles, state IDLE, r_valid never 1; without the macro busy stays 1.
REQ-035 Spurious dec_out_valid in LOAD_H -> ignored, r_valid stays 0.
